// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants: opcodes, field-bundle classes, funct3 values
// and loader FSM states.
package rv32_pkg;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;

  localparam logic [3:0] CLS_R     = 4'd0;
  localparam logic [3:0] CLS_I     = 4'd1;
  localparam logic [3:0] CLS_LOAD  = 4'd2;
  localparam logic [3:0] CLS_S     = 4'd3;
  localparam logic [3:0] CLS_B     = 4'd4;
  localparam logic [3:0] CLS_LUI   = 4'd5;
  localparam logic [3:0] CLS_AUIPC = 4'd6;
  localparam logic [3:0] CLS_JAL   = 4'd7;
  localparam logic [3:0] CLS_JALR  = 4'd8;

  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_LD3  = 3'b011;
  localparam logic [2:0] F3_LD6  = 3'b110;
  localparam logic [2:0] F3_LD7  = 3'b111;
  localparam logic [2:0] F3_B2   = 3'b010;
  localparam logic [2:0] F3_B3   = 3'b011;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/instr_encode_loader_if.sv
// Field-bundle stream (valid/ready) into the loader and the imem write port out of it.
// master = bundle producer / memory side, slave = loader.
interface instr_encode_loader_if #(parameter int ADDR_W = 8);

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_class;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_func3;
  logic              in_func7;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output in_valid, in_class, in_rd, in_rs1, in_rs2, in_func3, in_func7, in_imm, in_last,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_func3, in_func7, in_imm, in_last,
    output in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/instr_word_encode.sv
// Combinational RV32I field packer: builds the 32-bit word and flags field
// combinations that have no legal encoding. Zero latency, no backpressure.
module instr_word_encode
  import rv32_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  func3,
  input  logic        func7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic fit12;
  logic fit13;
  logic fit21;
  logic shift_op;

  // A signed value fits N bits when everything above bit N-2 is a copy of the sign.
  assign fit12    = (&imm[31:11]) | ~(|imm[31:11]);
  assign fit13    = (&imm[31:12]) | ~(|imm[31:12]);
  assign fit21    = (&imm[31:20]) | ~(|imm[31:20]);
  assign shift_op = (func3 == F3_SLL) || (func3 == F3_SR);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (cls)
      CLS_R: word = {1'b0, func7, 5'b0, rs2, rs1, func3, rd, OP_R};
      CLS_I: begin
        if (shift_op) begin
          word    = {1'b0, func7 & (func3 == F3_SR), 5'b0, imm[4:0], rs1, func3, rd, OP_I};
          illegal = (|imm[11:5]) | ~fit12;
        end else begin
          word    = {imm[11:0], rs1, func3, rd, OP_I};
          illegal = ~fit12;
        end
      end
      CLS_LOAD: begin
        word    = {imm[11:0], rs1, func3, rd, OP_LOAD};
        illegal = ~fit12 | (func3 == F3_LD3) | (func3 == F3_LD6) | (func3 == F3_LD7);
      end
      CLS_S: begin
        word    = {imm[11:5], rs2, rs1, func3, imm[4:0], OP_S};
        illegal = ~fit12 | (func3 > F3_SW);
      end
      CLS_B: begin
        word    = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], OP_B};
        illegal = imm[0] | ~fit13 | (func3 == F3_B2) | (func3 == F3_B3);
      end
      CLS_LUI:   word = {imm[31:12], rd, OP_LUI};
      CLS_AUIPC: word = {imm[31:12], rd, OP_AUIPC};
      CLS_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        illegal = imm[0] | ~fit21;
      end
      CLS_JALR: begin
        word    = {imm[11:0], rs1, func3, rd, OP_JALR};
        illegal = ~fit12 | (func3 != F3_JALR);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Streams encoded RV32I words into imem at sequential addresses; write lands 1 cycle
// after accept, 1 bundle/cycle; in_ready only in LOAD, dropped after last/capacity accept.
module instr_encode_loader
  import rv32_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  instr_encode_loader_if.slave  bus,
  output logic                  done,
  output logic                  overflow,
  output logic                  err,
  output logic [7:0]            err_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [1:0]        state;
  logic [31:0]       enc_word;
  logic              enc_ill;
  logic              p_vld;
  logic              p_ill;
  logic [31:0]       p_word;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              wr_fire;
  logic              slot_last;

  instr_word_encode u_enc (
    .cls     (bus.in_class),
    .rd      (bus.in_rd),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .func3   (bus.in_func3),
    .func7   (bus.in_func7),
    .imm     (bus.in_imm),
    .word    (enc_word),
    .illegal (enc_ill)
  );

  assign bus.in_ready = (state == ST_LOAD);
  assign accept       = bus.in_valid & bus.in_ready & ~start;
  // A restart kills the write already sitting in the pipeline register.
  assign wr_fire      = p_vld & ~p_ill & ~start;
  // Address the bundle accepted this cycle will occupy, accounting for the write in flight.
  assign slot_last    = wr_fire ? (addr == ADDR_MAX - ADDR_ONE) : (addr == ADDR_MAX);

  assign bus.wr_en    = wr_fire;
  assign bus.wr_addr  = addr;
  assign bus.wr_data  = p_word;
  assign done         = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      p_vld    <= 1'b0;
      p_ill    <= 1'b0;
      p_word   <= '0;
      addr     <= '0;
      overflow <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else if (start) begin
      state    <= ST_LOAD;
      p_vld    <= 1'b0;
      addr     <= base_addr;
      overflow <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      p_vld <= accept;
      if (accept) begin
        p_word <= enc_word;
        p_ill  <= enc_ill;
      end
      if (wr_fire && (addr != ADDR_MAX)) begin
        addr <= addr + ADDR_ONE;
      end
      if (p_vld && p_ill) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
      if (accept && slot_last && !bus.in_last) begin
        overflow <= 1'b1;
      end
      case (state)
        ST_LOAD:  if (accept && (bus.in_last || slot_last)) state <= ST_DRAIN;
        ST_DRAIN: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: encoding table plus handshake, capacity,
// restart and async-reset sequences.
module tb_instr_encode_loader;

  typedef struct {
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic        ill;
    logic [31:0] word;
  } vec_t;

  localparam int NV = 23;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic       done;
  logic       overflow;
  logic       err;
  logic [7:0] err_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  vec_t vecs [NV];

  instr_encode_loader_if #(.ADDR_W(8)) bus ();

  instr_encode_loader #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus.slave),
    .done      (done),
    .overflow  (overflow),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.in_valid = 1'b0;
    bus.in_class = '0;
    bus.in_rd    = '0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    bus.in_func3 = '0;
    bus.in_func7 = 1'b0;
    bus.in_imm   = '0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drive(input vec_t v, input logic last);
    bus.in_valid = 1'b1;
    bus.in_class = v.cls;
    bus.in_rd    = v.rd;
    bus.in_rs1   = v.rs1;
    bus.in_rs2   = v.rs2;
    bus.in_func3 = v.f3;
    bus.in_func7 = v.f7;
    bus.in_imm   = v.imm;
    bus.in_last  = last;
  endtask

  task automatic do_start(input logic [7:0] base);
    start     = 1'b1;
    base_addr = base;
    step();
    start     = 1'b0;
  endtask

  initial begin
    vec_t v;
    vec_t bad;
    int   exp_addr;
    int   exp_err;
    int   ea;

    //          cls    rd     rs1    rs2    f3     f7    imm            ill   word
    vecs[0]  = '{4'd0, 5'd3,  5'd1,  5'd2,  3'd0,  1'b0, 32'h0,         1'b0, 32'h002081B3};
    vecs[1]  = '{4'd0, 5'd3,  5'd1,  5'd2,  3'd0,  1'b1, 32'h0,         1'b0, 32'h402081B3};
    vecs[2]  = '{4'd1, 5'd1,  5'd0,  5'd0,  3'd0,  1'b0, 32'd5,         1'b0, 32'h00500093};
    vecs[3]  = '{4'd5, 5'd5,  5'd0,  5'd0,  3'd0,  1'b0, 32'h12345000,  1'b0, 32'h123452B7};
    vecs[4]  = '{4'd1, 5'd2,  5'd1,  5'd0,  3'd5,  1'b1, 32'd3,         1'b0, 32'h4030D113};
    vecs[5]  = '{4'd3, 5'd0,  5'd2,  5'd5,  3'd2,  1'b0, 32'hFFFFFFFC,  1'b0, 32'hFE512E23};
    vecs[6]  = '{4'd7, 5'd1,  5'd0,  5'd0,  3'd0,  1'b0, 32'd8,         1'b0, 32'h008000EF};
    vecs[7]  = '{4'd8, 5'd0,  5'd1,  5'd0,  3'd0,  1'b0, 32'd0,         1'b0, 32'h00008067};
    vecs[8]  = '{4'd2, 5'd5,  5'd2,  5'd0,  3'd2,  1'b0, 32'h7FF,       1'b0, 32'h7FF12283};
    vecs[9]  = '{4'd6, 5'd1,  5'd0,  5'd0,  3'd0,  1'b0, 32'hFFFFF000,  1'b0, 32'hFFFFF097};
    vecs[10] = '{4'd4, 5'd0,  5'd0,  5'd0,  3'd0,  1'b0, 32'hFFFFF000,  1'b0, 32'h80000063};
    vecs[11] = '{4'd7, 5'd0,  5'd0,  5'd0,  3'd0,  1'b0, 32'h000FFFFE,  1'b0, 32'h7FFFF06F};
    vecs[12] = '{4'd1, 5'd1,  5'd1,  5'd0,  3'd0,  1'b0, 32'h800,       1'b1, 32'h0};
    vecs[13] = '{4'd1, 5'd1,  5'd1,  5'd0,  3'd1,  1'b0, 32'h20,        1'b1, 32'h0};
    vecs[14] = '{4'd2, 5'd1,  5'd1,  5'd0,  3'd3,  1'b0, 32'h0,         1'b1, 32'h0};
    vecs[15] = '{4'd3, 5'd0,  5'd1,  5'd2,  3'd3,  1'b0, 32'h0,         1'b1, 32'h0};
    vecs[16] = '{4'd4, 5'd0,  5'd1,  5'd2,  3'd2,  1'b0, 32'd8,         1'b1, 32'h0};
    vecs[17] = '{4'd4, 5'd0,  5'd1,  5'd2,  3'd0,  1'b0, 32'h1000,      1'b1, 32'h0};
    vecs[18] = '{4'd8, 5'd0,  5'd1,  5'd0,  3'd1,  1'b0, 32'h0,         1'b1, 32'h0};
    vecs[19] = '{4'd7, 5'd1,  5'd0,  5'd0,  3'd0,  1'b0, 32'h00100000,  1'b1, 32'h0};
    vecs[20] = '{4'd1, 5'd1,  5'd1,  5'd0,  3'd0,  1'b0, 32'hFFFFF7FF,  1'b1, 32'h0};
    vecs[21] = '{4'd9, 5'd1,  5'd1,  5'd1,  3'd0,  1'b0, 32'h0,         1'b1, 32'h0};
    vecs[22] = '{4'd1, 5'd1,  5'd1,  5'd0,  3'd1,  1'b1, 32'd4,         1'b0, 32'h00409093};

    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    idle_bus();
    #3;
    check("rst_wr_en",    bus.wr_en,    0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_wr_addr",  bus.wr_addr,  0);
    check("rst_wr_data",  bus.wr_data,  0);
    check("rst_done",     done,         0);
    check("rst_overflow", overflow,     0);
    check("rst_err",      err,          0);
    check("rst_err_cnt",  err_cnt,      0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Bundles offered in IDLE are not taken.
    drive(vecs[0], 1'b0);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 0);
    check("idle_wr_en",    bus.wr_en,    0);
    step();

    // Encoding table, one bundle every other cycle.
    do_start(8'h10);
    exp_addr = 32'h10;
    exp_err  = 0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i], 1'b0);
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_wr_en", i),   bus.wr_en,   !vecs[i].ill);
      check($sformatf("v%0d_wr_addr", i), bus.wr_addr, exp_addr);
      if (!vecs[i].ill) begin
        check($sformatf("v%0d_wr_data", i), bus.wr_data, vecs[i].word);
        exp_addr++;
      end else begin
        exp_err++;
      end
      step();
    end
    check("tbl_err",     err,     1);
    check("tbl_err_cnt", err_cnt, exp_err);
    check("tbl_addr",    bus.wr_addr, exp_addr);

    // beq with in_last: write, then done two cycles after accept, then IDLE.
    do_start(8'h40);
    check("c_err_clr",     err,     0);
    check("c_err_cnt_clr", err_cnt, 0);
    v = '{4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8, 1'b0, 32'h00208463};
    drive(v, 1'b1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("c_wr_en",    bus.wr_en,    1);
    check("c_wr_data",  bus.wr_data,  32'h00208463);
    check("c_wr_addr",  bus.wr_addr,  32'h40);
    check("c_in_ready", bus.in_ready, 0);
    check("c_done_n1",  done,         0);
    step();
    @(negedge clk);
    check("c_done",     done,      1);
    check("c_wr_en_n2", bus.wr_en, 0);
    step();
    @(negedge clk);
    check("c_done_n3",     done,         0);
    check("c_in_ready_n3", bus.in_ready, 0);
    check("c_overflow",    overflow,     0);
    step();

    // Misaligned JAL then illegal class, back to back.
    do_start(8'h20);
    v = '{4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3, 1'b1, 32'h0};
    drive(v, 1'b0);
    step();
    bad = '{4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'h0, 1'b1, 32'h0};
    drive(bad, 1'b0);
    @(negedge clk);
    check("d_wr_en_1", bus.wr_en, 0);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("d_wr_en_2", bus.wr_en, 0);
    step();
    @(negedge clk);
    check("d_err",     err,         1);
    check("d_err_cnt", err_cnt,     2);
    check("d_wr_addr", bus.wr_addr, 32'h20);
    step();

    // Capacity: four slots 0xFC..0xFF, fifth bundle refused.
    do_start(8'hFC);
    for (int k = 0; k < 6; k++) begin
      if (k < 5) drive(vecs[0], 1'b0);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      ea = (k == 0) ? 252 : ((251 + k > 255) ? 255 : 251 + k);
      check($sformatf("e%0d_in_ready", k), bus.in_ready, (k < 4));
      check($sformatf("e%0d_wr_en", k),    bus.wr_en,    (k >= 1 && k <= 4));
      check($sformatf("e%0d_wr_addr", k),  bus.wr_addr,  ea);
      check($sformatf("e%0d_done", k),     done,         (k == 5));
      step();
    end
    check("e_overflow", overflow,    1);
    check("e_addr_end", bus.wr_addr, 32'hFF);

    // Restart mid-stream: in-flight write dropped, counters cleared.
    do_start(8'h30);
    drive(bad, 1'b0);
    step();
    drive(vecs[2], 1'b0);
    step();
    drive(vecs[3], 1'b0);
    @(negedge clk);
    check("f_wr_en",   bus.wr_en,   1);
    check("f_wr_addr", bus.wr_addr, 32'h30);
    check("f_wr_data", bus.wr_data, 32'h00500093);
    check("f_err_cnt", err_cnt,     1);
    step();
    drive(vecs[0], 1'b0);
    start     = 1'b1;
    base_addr = 8'h50;
    @(negedge clk);
    check("f_drop_wr_en", bus.wr_en, 0);
    step();
    start        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("f_rs_wr_en",    bus.wr_en,    0);
    check("f_rs_wr_addr",  bus.wr_addr,  32'h50);
    check("f_rs_err_cnt",  err_cnt,      0);
    check("f_rs_err",      err,          0);
    check("f_rs_in_ready", bus.in_ready, 1);
    step();
    drive(vecs[1], 1'b0);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("f_nw_wr_en",   bus.wr_en,   1);
    check("f_nw_wr_addr", bus.wr_addr, 32'h50);
    check("f_nw_wr_data", bus.wr_data, 32'h402081B3);

    // Async reset in the middle of a write cycle.
    #2 rst_n = 1'b0;
    #1;
    check("g_wr_en",    bus.wr_en,    0);
    check("g_in_ready", bus.in_ready, 0);
    check("g_wr_addr",  bus.wr_addr,  0);
    check("g_wr_data",  bus.wr_data,  0);
    check("g_done",     done,         0);
    check("g_err_cnt",  err_cnt,      0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("g_idle_in_ready", bus.in_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
